// File: rtl/fetch_stage_p.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address and
// loads the IF/ID pipeline register with stall, flush and branch-redirect control.
module fetch_stage_p #(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       INSTR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int unsigned       PC_INC     = 4,
  parameter int unsigned       ALIGN_BITS = 2,
  parameter int unsigned       CNT_W      = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0]  if_id_pc_next,
  output logic               if_id_valid,
  output logic               misalign_err,
  output logic [CNT_W-1:0]   fetch_count
);

  typedef enum logic [1:0] {
    ACT_FETCH,
    ACT_HOLD,
    ACT_BUBBLE,
    ACT_REDIRECT
  } action_e;

  // A zero mask (ALIGN_BITS = 0) makes every target count as aligned.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((64'd1 << ALIGN_BITS) - 64'd1);
  localparam logic [ADDR_W-1:0] INC        = ADDR_W'(PC_INC);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus;
  logic              target_aligned;
  logic              count_full;
  action_e           action;

  assign imem_addr      = pc;
  assign pc_plus        = pc + INC;
  assign target_aligned = (branch_target & ALIGN_MASK) == '0;
  assign count_full     = &fetch_count;

  always_comb begin
    // NOTE: the default is assigned first so every path drives action and no latch is inferred.
    action = ACT_FETCH;
    if (branch_taken) begin
      action = ACT_REDIRECT;
    end else if (stall) begin
      action = ACT_HOLD;
    end else if (flush) begin
      action = ACT_BUBBLE;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc            <= RESET_PC;
      if_id_instr   <= '0;
      if_id_pc_next <= '0;
      if_id_valid   <= 1'b0;
      misalign_err  <= 1'b0;
      fetch_count   <= '0;
    end else begin
      unique case (action)
        ACT_FETCH: begin
          pc            <= pc_plus;
          if_id_instr   <= imem_rdata;
          if_id_pc_next <= pc_plus;
          if_id_valid   <= 1'b1;
          if (!count_full) begin
            fetch_count <= fetch_count + CNT_W'(1);
          end
        end
        ACT_BUBBLE: begin
          pc            <= pc_plus;
          if_id_instr   <= '0;
          if_id_pc_next <= '0;
          if_id_valid   <= 1'b0;
        end
        ACT_REDIRECT: begin
          // The wrong-path word fetched this cycle is squashed either way.
          if_id_instr   <= '0;
          if_id_pc_next <= '0;
          if_id_valid   <= 1'b0;
          if (target_aligned) begin
            pc <= branch_target;
          end else begin
            misalign_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage_p.sv
// Self-checking bench for fetch_stage_p: directed vector table, a small wrap/saturation
// instance, and a randomized run against a behavioural model of the fetch rules.
module tb_fetch_stage_p;

  logic        clk = 1'b0;
  logic        reset, stall, flush, branch_taken;
  logic [31:0] branch_target, imem_addr, imem_rdata, if_id_instr, if_id_pc_next;
  logic        if_id_valid, misalign_err;
  logic [15:0] fetch_count;

  logic        s_reset, s_stall, s_flush, s_branch;
  logic [7:0]  s_target, s_addr, s_pc_next;
  logic [31:0] s_rdata, s_instr;
  logic        s_valid, s_err;
  logic [1:0]  s_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign imem_rdata = 32'hA500_0000 | imem_addr;
  assign s_rdata    = 32'hA500_0000 | {24'h0, s_addr};

  fetch_stage_p dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .if_id_instr(if_id_instr), .if_id_pc_next(if_id_pc_next),
    .if_id_valid(if_id_valid), .misalign_err(misalign_err),
    .fetch_count(fetch_count)
  );

  fetch_stage_p #(.ADDR_W(8), .RESET_PC(8'hFC), .CNT_W(2)) dut_small (
    .clk(clk), .reset(s_reset), .stall(s_stall), .flush(s_flush),
    .branch_taken(s_branch), .branch_target(s_target),
    .imem_addr(s_addr), .imem_rdata(s_rdata),
    .if_id_instr(s_instr), .if_id_pc_next(s_pc_next),
    .if_id_valid(s_valid), .misalign_err(s_err),
    .fetch_count(s_count)
  );

  typedef struct {
    logic        rst, stl, fls, br;
    logic [31:0] tgt;
    logic [31:0] addr, instr, pc_next;
    logic        valid, err;
    logic [15:0] count;
  } vec_t;

  vec_t vecs[$];

  // Reference model state
  longint m_pc, m_instr, m_pcn, m_cnt;
  bit     m_valid, m_err;
  logic   r_rst, r_stl, r_fls, r_br;
  logic [31:0] r_tgt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_step(input bit rst, input bit stl, input bit fls, input bit br,
                            input longint tgt);
    if (rst) begin
      m_pc = 0; m_instr = 0; m_pcn = 0; m_valid = 0; m_err = 0; m_cnt = 0;
    end else if (br) begin
      m_instr = 0; m_pcn = 0; m_valid = 0;
      if (tgt % 4 == 0) m_pc = tgt;
      else m_err = 1;
    end else if (stl) begin
      // everything holds
    end else if (fls) begin
      m_instr = 0; m_pcn = 0; m_valid = 0;
      m_pc = (m_pc + 4) % (64'd1 << 32);
    end else begin
      m_instr = 64'hA500_0000 | m_pc;
      m_pcn   = (m_pc + 4) % (64'd1 << 32);
      m_pc    = m_pcn;
      m_valid = 1;
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //            rst  stl  fls  br   tgt        addr       instr          pc_next    v  err cnt
    vecs.push_back('{1'b1,1'b0,1'b0,1'b0,32'h0,   32'h0,   32'h0,         32'h0,   1'b0,1'b0,16'd0});
    vecs.push_back('{1'b0,1'b0,1'b0,1'b0,32'h0,   32'h4,   32'hA500_0000, 32'h4,   1'b1,1'b0,16'd1});
    vecs.push_back('{1'b0,1'b0,1'b0,1'b0,32'h0,   32'h8,   32'hA500_0004, 32'h8,   1'b1,1'b0,16'd2});
    vecs.push_back('{1'b0,1'b1,1'b0,1'b0,32'h0,   32'h8,   32'hA500_0004, 32'h8,   1'b1,1'b0,16'd2});
    vecs.push_back('{1'b0,1'b1,1'b1,1'b0,32'h0,   32'h8,   32'hA500_0004, 32'h8,   1'b1,1'b0,16'd2});
    vecs.push_back('{1'b0,1'b0,1'b0,1'b0,32'h0,   32'hC,   32'hA500_0008, 32'hC,   1'b1,1'b0,16'd3});
    vecs.push_back('{1'b0,1'b1,1'b1,1'b1,32'h100, 32'h100, 32'h0,         32'h0,   1'b0,1'b0,16'd3});
    vecs.push_back('{1'b0,1'b0,1'b0,1'b0,32'h0,   32'h104, 32'hA500_0100, 32'h104, 1'b1,1'b0,16'd4});
    vecs.push_back('{1'b0,1'b0,1'b0,1'b1,32'h20,  32'h20,  32'h0,         32'h0,   1'b0,1'b0,16'd4});
    vecs.push_back('{1'b0,1'b0,1'b0,1'b1,32'h102, 32'h20,  32'h0,         32'h0,   1'b0,1'b1,16'd4});
    vecs.push_back('{1'b0,1'b0,1'b0,1'b0,32'h0,   32'h24,  32'hA500_0020, 32'h24,  1'b1,1'b1,16'd5});
    vecs.push_back('{1'b0,1'b0,1'b0,1'b0,32'h0,   32'h28,  32'hA500_0024, 32'h28,  1'b1,1'b1,16'd6});
    vecs.push_back('{1'b0,1'b0,1'b0,1'b0,32'h0,   32'h2C,  32'hA500_0028, 32'h2C,  1'b1,1'b1,16'd7});
    vecs.push_back('{1'b0,1'b0,1'b0,1'b0,32'h0,   32'h30,  32'hA500_002C, 32'h30,  1'b1,1'b1,16'd8});
    vecs.push_back('{1'b0,1'b0,1'b0,1'b0,32'h0,   32'h34,  32'hA500_0030, 32'h34,  1'b1,1'b1,16'd9});
    vecs.push_back('{1'b0,1'b0,1'b0,1'b1,32'h10,  32'h10,  32'h0,         32'h0,   1'b0,1'b1,16'd9});
    vecs.push_back('{1'b0,1'b0,1'b1,1'b0,32'h0,   32'h14,  32'h0,         32'h0,   1'b0,1'b1,16'd9});
    vecs.push_back('{1'b1,1'b1,1'b0,1'b1,32'h200, 32'h0,   32'h0,         32'h0,   1'b0,1'b0,16'd0});
    vecs.push_back('{1'b0,1'b0,1'b0,1'b0,32'h0,   32'h4,   32'hA500_0000, 32'h4,   1'b1,1'b0,16'd1});

    s_reset = 1'b1; s_stall = 1'b0; s_flush = 1'b0; s_branch = 1'b0; s_target = 8'h0;

    foreach (vecs[i]) begin
      reset = vecs[i].rst; stall = vecs[i].stl; flush = vecs[i].fls;
      branch_taken = vecs[i].br; branch_target = vecs[i].tgt;
      step();
      check($sformatf("vec%0d addr", i),    imem_addr,     vecs[i].addr);
      check($sformatf("vec%0d instr", i),   if_id_instr,   vecs[i].instr);
      check($sformatf("vec%0d pc_next", i), if_id_pc_next, vecs[i].pc_next);
      check($sformatf("vec%0d valid", i),   if_id_valid,   vecs[i].valid);
      check($sformatf("vec%0d err", i),     misalign_err,  vecs[i].err);
      check($sformatf("vec%0d count", i),   fetch_count,   vecs[i].count);
    end

    // Narrow instance: PC wrap from 0xFC and 2-bit counter saturation
    s_reset = 1'b1;
    step();
    check("small reset addr", s_addr, 8'hFC);
    check("small reset count", s_count, 2'd0);
    s_reset = 1'b0;
    step();
    check("small wrap pc_next", s_pc_next, 8'h00);
    check("small wrap addr", s_addr, 8'h00);
    check("small wrap instr", s_instr, 32'hA500_00FC);
    for (int k = 0; k < 4; k++) step();
    check("small sat count", s_count, 2'd3);
    check("small addr after 5", s_addr, 8'h10);
    check("small instr after 5", s_instr, 32'hA500_000C);
    s_flush = 1'b1;
    step();
    s_flush = 1'b0;
    check("small flush valid", s_valid, 1'b0);
    check("small flush count", s_count, 2'd3);
    check("small flush addr", s_addr, 8'h14);
    s_branch = 1'b1; s_target = 8'h41;
    step();
    s_branch = 1'b0;
    check("small misalign err", s_err, 1'b1);
    check("small misalign addr", s_addr, 8'h14);

    // Randomized run against the behavioural model
    reset = 1'b1; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; branch_target = '0;
    model_step(1, 0, 0, 0, 0);
    step();
    for (int i = 0; i < 3000; i++) begin
      r_rst = ($urandom_range(0, 63) == 0);
      r_stl = ($urandom_range(0, 3) == 0);
      r_fls = ($urandom_range(0, 5) == 0);
      r_br  = ($urandom_range(0, 7) == 0);
      r_tgt = $urandom;
      if ($urandom_range(0, 3) != 0) r_tgt[1:0] = 2'b00;
      if ($urandom_range(0, 15) == 0) r_tgt = 32'hFFFF_FFF4;
      model_step(r_rst, r_stl, r_fls, r_br, longint'(r_tgt));
      reset = r_rst; stall = r_stl; flush = r_fls; branch_taken = r_br; branch_target = r_tgt;
      step();
      check($sformatf("rnd%0d addr", i),    imem_addr,     m_pc);
      check($sformatf("rnd%0d instr", i),   if_id_instr,   m_instr);
      check($sformatf("rnd%0d pc_next", i), if_id_pc_next, m_pcn);
      check($sformatf("rnd%0d valid", i),   if_id_valid,   m_valid);
      check($sformatf("rnd%0d err", i),     misalign_err,  m_err);
      check($sformatf("rnd%0d count", i),   fetch_count,   m_cnt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
